// File: rtl/stream_pattern_master_if.sv
// stream_channel: AXI-Stream style channel with master and slave views
interface stream_channel #(
  parameter int DATA_W = 32,
  parameter int USER_W = 8,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
);
  logic                  t_valid;
  logic                  t_ready;
  logic                  t_last;
  logic [DATA_W-1:0]     t_data;
  logic [DATA_W/8-1:0]   t_strb;
  logic [DATA_W/8-1:0]   t_keep;
  logic [USER_W-1:0]     t_user;
  logic [ID_W-1:0]       t_id;
  logic [DEST_W-1:0]     t_dest;
  modport master(output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, input t_ready);
  modport slave(input t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, output t_ready);
endinterface

// File: rtl/stream_pattern_master.sv
// stream_pattern_master: packetised counter/LFSR traffic source on a stream_channel
module stream_pattern_master #(
  parameter int          MODE      = 1,
  parameter int          PKT_LEN   = 16,
  parameter int          PKT_COUNT = 0,
  parameter int          GAP       = 0,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
  parameter int          ID        = 0,
  parameter int          DEST      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  stream_channel.master master,
  output logic          busy,
  output logic          done,
  output logic [31:0]   pkt_cnt
);
  localparam int DW  = $bits(master.t_data);
  localparam int UW  = $bits(master.t_user);
  localparam int IW  = $bits(master.t_id);
  localparam int DSW = $bits(master.t_dest);
  localparam int BW  = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam int RN  = (DW + 31) / 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  logic [1:0]     state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [7:0]     gap_q, gap_d;
  logic [31:0]    word_q, word_d, lfsr_q, lfsr_d, pkt_q, pkt_d;
  logic           done_q, done_d;
  logic           valid, last, acc, fin;
  logic [RN*32-1:0] rep;
  // beat handshake decode; every output is derived from registers so it holds while stalled
  always_comb begin
    valid = state_q == S_SEND;
    last  = valid && beat_q == BW'(PKT_LEN - 1);
    acc   = valid && master.t_ready;
    fin   = acc && last;
    rep   = {RN{lfsr_q}};
  end
  // packet sequencing: whole packets only, optional gap, stop after PKT_COUNT
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    done_d  = done_q;
    beat_d  = fin ? '0 : acc ? beat_q + 1'b1 : beat_q;
    word_d  = acc ? word_q + 32'd1 : word_q;
    lfsr_d  = acc ? ({1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0)) : lfsr_q;
    pkt_d   = fin ? pkt_q + 32'd1 : pkt_q;
    if (state_q == S_IDLE && enable && !done_q && MODE != 0) state_d = S_SEND;
    if (fin) begin
      if (PKT_COUNT != 0 && pkt_q + 32'd1 == 32'(PKT_COUNT)) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (GAP > 0) begin
        state_d = S_GAP;
        gap_d   = '0;
      end else state_d = enable ? S_SEND : S_IDLE;
    end
    if (state_q == S_GAP) begin
      gap_d = gap_q + 8'd1;
      if (gap_q == 8'(GAP - 1)) state_d = enable ? S_SEND : S_IDLE;
    end
  end
  // state registers; reset abandons any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      pkt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      lfsr_q  <= lfsr_d;
      pkt_q   <= pkt_d;
      done_q  <= done_d;
    end
  end
  assign master.t_valid = valid;
  assign master.t_last  = last;
  assign master.t_data  = valid ? (MODE == 2 ? rep[DW-1:0] : DW'(word_q)) : '0;
  assign master.t_strb  = valid ? '1 : '0;
  assign master.t_keep  = valid ? '1 : '0;
  assign master.t_id    = valid ? IW'(ID) : '0;
  assign master.t_dest  = valid ? DSW'(DEST) : '0;
  assign master.t_user  = valid ? UW'(pkt_q) : '0;
  assign busy    = valid;
  assign done    = done_q;
  assign pkt_cnt = pkt_q;
endmodule

// File: tb/tb_stream_pattern_master.sv
// tb_stream_pattern_master: randomized self-checking bench against a behavioural stream model
module tb_stream_pattern_master;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, rdy_c = 1'b1;
  logic en_a = 0, en_b = 0, en_c = 0, en_d = 0, en_e = 0, en_z = 0;
  logic bz_a, bz_b, bz_c, bz_d, bz_e, bz_z, dn_a, dn_b, dn_c, dn_d, dn_e, dn_z;
  logic [31:0] pc_a, pc_b, pc_c, pc_d, pc_e, pc_z;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  stream_channel #(.DATA_W(32)) ch_a();
  stream_channel #(.DATA_W(32)) ch_b();
  stream_channel #(.DATA_W(16)) ch_c();
  stream_channel #(.DATA_W(64)) ch_d();
  stream_channel #(.DATA_W(32)) ch_e();
  stream_channel #(.DATA_W(32)) ch_z();
  assign ch_a.t_ready = rdy;
  assign ch_b.t_ready = rdy;
  assign ch_c.t_ready = rdy_c;
  assign ch_d.t_ready = rdy;
  assign ch_e.t_ready = rdy;
  assign ch_z.t_ready = rdy;
  stream_pattern_master #(.MODE(1), .PKT_LEN(4), .PKT_COUNT(2), .GAP(0), .ID(3), .DEST(5)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .master(ch_a), .busy(bz_a), .done(dn_a), .pkt_cnt(pc_a));
  stream_pattern_master #(.MODE(1), .PKT_LEN(3), .PKT_COUNT(0), .GAP(2)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .master(ch_b), .busy(bz_b), .done(dn_b), .pkt_cnt(pc_b));
  stream_pattern_master #(.MODE(1), .PKT_LEN(5)) u_c (
    .clk(clk), .rst(rst), .enable(en_c), .master(ch_c), .busy(bz_c), .done(dn_c), .pkt_cnt(pc_c));
  stream_pattern_master #(.MODE(2), .PKT_LEN(4), .LFSR_SEED(32'h1)) u_d (
    .clk(clk), .rst(rst), .enable(en_d), .master(ch_d), .busy(bz_d), .done(dn_d), .pkt_cnt(pc_d));
  stream_pattern_master #(.MODE(1), .PKT_LEN(4)) u_e (
    .clk(clk), .rst(rst), .enable(en_e), .master(ch_e), .busy(bz_e), .done(dn_e), .pkt_cnt(pc_e));
  stream_pattern_master #(.MODE(0), .PKT_LEN(4)) u_z (
    .clk(clk), .rst(rst), .enable(en_z), .master(ch_z), .busy(bz_z), .done(dn_z), .pkt_cnt(pc_z));

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {en_a, en_b, en_c, en_d, en_e, en_z} = '0;
    rdy = 1'b1;
    rdy_c = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if ({ch_a.t_valid, ch_a.t_last, ch_a.t_data, ch_a.t_strb, ch_a.t_keep, ch_a.t_user, ch_a.t_id, ch_a.t_dest} !== '0) begin
      bad++; $display("FAIL reset_outputs valid=%b data=%h strb=%h id=%h want all zero", ch_a.t_valid, ch_a.t_data, ch_a.t_strb, ch_a.t_id);
    end
    total++;
    if ({bz_a, dn_a, pc_a} !== '0) begin
      bad++; $display("FAIL reset_status busy=%b done=%b pkt_cnt=%0d want 0", bz_a, dn_a, pc_a);
    end
    total++;
    if (ch_d.t_data !== 64'h0) begin
      bad++; $display("FAIL reset_lfsr_data got=%h want 0", ch_d.t_data);
    end
  endtask

  task automatic test_count();
    do_reset();
    en_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      logic ev;
      tick();
      ev = c <= 8;
      total++;
      if (ch_a.t_valid !== ev || bz_a !== ev) begin
        bad++; $display("FAIL count_valid c=%0d valid=%b busy=%b want %b", c, ch_a.t_valid, bz_a, ev);
      end
      if (ev) begin
        total++;
        if (ch_a.t_data !== 32'(c - 1) || ch_a.t_last !== ((c - 1) % 4 == 3) || ch_a.t_user !== 8'((c - 1) / 4)) begin
          bad++; $display("FAIL count_beat c=%0d data=%0d last=%b user=%0d want %0d %b %0d", c, ch_a.t_data, ch_a.t_last, ch_a.t_user, c - 1, (c - 1) % 4 == 3, (c - 1) / 4);
        end
        total++;
        if (ch_a.t_id !== 4'd3 || ch_a.t_dest !== 4'd5 || ch_a.t_strb !== 4'hf || ch_a.t_keep !== 4'hf) begin
          bad++; $display("FAIL count_sideband id=%h dest=%h strb=%h keep=%h want 3 5 f f", ch_a.t_id, ch_a.t_dest, ch_a.t_strb, ch_a.t_keep);
        end
      end
      if (c == 8 || c == 9) begin
        total++;
        if (dn_a !== (c == 9) || pc_a !== 32'(c == 9 ? 2 : 1)) begin
          bad++; $display("FAIL count_done c=%0d done=%b pkt_cnt=%0d want %b %0d", c, dn_a, pc_a, c == 9, c == 9 ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    en_b = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      int p, k;
      tick();
      p = (c - 1) % 5;
      k = (c - 1) / 5;
      total++;
      if (ch_b.t_valid !== (p < 3)) begin
        bad++; $display("FAIL gap_valid c=%0d valid=%b want %b", c, ch_b.t_valid, p < 3);
      end
      if (p < 3) begin
        total++;
        if (ch_b.t_data !== 32'(k * 3 + p) || ch_b.t_user !== 8'(k) || ch_b.t_last !== (p == 2)) begin
          bad++; $display("FAIL gap_beat c=%0d data=%0d user=%0d last=%b want %0d %0d %b", c, ch_b.t_data, ch_b.t_user, ch_b.t_last, k * 3 + p, k, p == 2);
        end
      end
    end
  endtask

  task automatic test_random_ready();
    int n = 0;
    logic held = 1'b0, pl = 1'b0;
    logic [15:0] pd = '0;
    do_reset();
    en_c = 1'b1;
    rdy_c = 1'($urandom_range(0, 1));
    for (int c = 0; c < 300; c++) begin
      tick();
      if (held) begin
        total++;
        if (ch_c.t_valid !== 1'b1 || ch_c.t_data !== pd || ch_c.t_last !== pl) begin
          bad++; $display("FAIL stall_hold c=%0d valid=%b data=%h last=%b want 1 %h %b", c, ch_c.t_valid, ch_c.t_data, ch_c.t_last, pd, pl);
        end
      end
      if (ch_c.t_valid === 1'b1) begin
        total++;
        if (ch_c.t_data !== 16'(n) || ch_c.t_last !== (n % 5 == 4) || ch_c.t_user !== 8'(n / 5)) begin
          bad++; $display("FAIL stall_seq n=%0d data=%0d last=%b user=%0d want %0d %b %0d", n, ch_c.t_data, ch_c.t_last, ch_c.t_user, n, n % 5 == 4, n / 5);
        end
      end
      rdy_c = 1'($urandom_range(0, 1));
      held = ch_c.t_valid && !rdy_c;
      if (ch_c.t_valid && rdy_c) n++;
      pd = ch_c.t_data;
      pl = ch_c.t_last;
    end
    total++;
    if (n < 50) begin
      bad++; $display("FAIL stall_progress beats=%0d want >=50", n);
    end
  endtask

  task automatic test_lfsr();
    logic [31:0] v = 32'h1;
    logic [31:0] tbl [3] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
    do_reset();
    en_d = 1'b1;
    for (int b = 0; b < 12; b++) begin
      tick();
      total++;
      if (ch_d.t_valid !== 1'b1 || ch_d.t_data !== {v, v}) begin
        bad++; $display("FAIL lfsr_beat b=%0d valid=%b data=%h want %h", b, ch_d.t_valid, ch_d.t_data, {v, v});
      end
      if (b < 3) begin
        total++;
        if (ch_d.t_data[31:0] !== tbl[b]) begin
          bad++; $display("FAIL lfsr_known b=%0d data=%h want %h", b, ch_d.t_data[31:0], tbl[b]);
        end
      end
      v = lfsr_step(v);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    en_e = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      total++;
      if (ch_e.t_valid !== (c <= 4) || bz_e !== (c <= 4)) begin
        bad++; $display("FAIL drop_valid c=%0d valid=%b busy=%b want %b", c, ch_e.t_valid, bz_e, c <= 4);
      end
      if (c <= 4) begin
        total++;
        if (ch_e.t_data !== 32'(c - 1) || ch_e.t_last !== (c == 4)) begin
          bad++; $display("FAIL drop_beat c=%0d data=%0d last=%b want %0d %b", c, ch_e.t_data, ch_e.t_last, c - 1, c == 4);
        end
      end
      if (c == 2) en_e = 1'b0;
    end
    total++;
    if (pc_e !== 32'd1) begin
      bad++; $display("FAIL drop_pkt_cnt got=%0d want 1", pc_e);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en_e = 1'b1;
    repeat (6) tick();
    total++;
    if (ch_e.t_valid !== 1'b1 || pc_e !== 32'd1 || ch_e.t_data !== 32'd5) begin
      bad++; $display("FAIL rst_pre valid=%b pkt_cnt=%0d data=%0d want 1 1 5", ch_e.t_valid, pc_e, ch_e.t_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if (ch_e.t_valid !== 1'b0 || pc_e !== 32'd0 || bz_e !== 1'b0) begin
      bad++; $display("FAIL rst_async valid=%b pkt_cnt=%0d busy=%b want 0 0 0", ch_e.t_valid, pc_e, bz_e);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (ch_e.t_valid !== 1'b1 || ch_e.t_data !== 32'd0 || ch_e.t_user !== 8'd0) begin
      bad++; $display("FAIL rst_restart valid=%b data=%0d user=%0d want 1 0 0", ch_e.t_valid, ch_e.t_data, ch_e.t_user);
    end
  endtask

  task automatic test_silent();
    do_reset();
    en_z = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({ch_z.t_valid, ch_z.t_data, ch_z.t_strb, ch_z.t_last, bz_z, dn_z, pc_z} !== '0) begin
        bad++; $display("FAIL silent c=%0d valid=%b data=%h strb=%h busy=%b done=%b want all zero", c, ch_z.t_valid, ch_z.t_data, ch_z.t_strb, bz_z, dn_z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_gap();
    test_random_ready();
    test_lfsr();
    test_enable_drop();
    test_rst_mid();
    test_silent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
